// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct values, ALU codes, datapath select codes, FSM states
// and the DECODE next-state lookup shared by the multicycle control unit.
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BNE = 6'b000101,
                           OP_XORI = 6'b001110;
    localparam logic [5:0] FN_JR = 6'b001000, FN_ADD = 6'b100000, FN_SUB = 6'b100010,
                           FN_SLT = 6'b101010, FN_SYSCALL = 6'b001100, FN_NOP = 6'b000000;
    localparam logic [5:0] ALU_ADD = 6'b100000, ALU_SUB = 6'b100010, ALU_SLT = 6'b101010,
                           ALU_XOR = 6'b100110, ALU_NOP = 6'b101100;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11;
    localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
    localparam logic [1:0] WB_ALUOUT = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10;
    localparam logic [1:0] SRCB_RT = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    // S_FETCH out of DECODE means the instruction retires there (NOP or illegal).
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_LW, OP_SW:  return S_MEM_ADDR;
            OP_XORI:       return S_EXEC_I;
            OP_BNE:        return S_BRANCH;
            OP_J, OP_JAL:  return S_JUMP;
            OP_RTYPE:
                case (fn)
                    FN_ADD, FN_SUB, FN_SLT: return S_EXEC_R;
                    FN_JR:                  return S_JUMP;
                    FN_SYSCALL:             return S_HALT;
                    default:                return S_FETCH;
                endcase
            default:       return S_FETCH;
        endcase
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts mem_ready-low cycles of one memory access.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       entering a memory state (restarts the count)
//   wait_cycle  in a memory state with mem_ready low
//   expire      this wait cycle brings the count to MEM_WAIT_MAX (never when it is 0)
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic wait_cycle,
    output logic expire
);
    localparam int W = MEM_WAIT_MAX < 1 ? 1 : $clog2(MEM_WAIT_MAX + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (wait_cycle) count <= count + 1'b1;

    assign expire = (MEM_WAIT_MAX != 0) && wait_cycle && (count == W'(MEM_WAIT_MAX - 1));
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM driving the datapath selects.
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode, funct         IR fields, stable from DECODE until instr_done
//   mem_ready             memory finishes the current access this cycle
//   pc_write.. alu_op     datapath controls, decoded from the state register
//   instr_done            pulse in the last cycle of every instruction
//   halted                FSM parked in HALT (SYSCALL or memory timeout)
//   illegal_instr         sticky: unknown opcode/funct seen (retired as NOP)
//   mem_timeout           sticky: a memory access waited MEM_WAIT_MAX cycles
module mips_multicycle_ctrl import mips_ctrl_pkg::*; #(
    parameter int ALUOP_W      = 6,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_src,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wb_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               halted,
    output logic               illegal_instr,
    output logic               mem_timeout
);
    state_t state, next, dec;
    logic   rtype, jal, wait_cycle, clear, expire;

    assign dec        = decode_next(opcode, funct);
    assign rtype      = opcode == OP_RTYPE;
    assign jal        = opcode == OP_JAL;
    assign wait_cycle = (state inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready;
    assign clear      = (next != state) && (next inside {S_FETCH, S_MEM_RD, S_MEM_WR});

    mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wait_cycle(wait_cycle), .expire(expire)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= S_IDLE;
            illegal_instr <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE && dec == S_FETCH && !(rtype && funct == FN_NOP)) illegal_instr <= 1'b1;
            if (expire) mem_timeout <= 1'b1;
        end

    always_comb begin
        next          = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_ALU;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = DST_RT;
        wb_sel        = WB_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = '0;
        instr_done    = 1'b0;
        halted        = 1'b0;
        case (state)
            S_IDLE:   next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                alu_op    = ALUOP_W'(ALU_ADD);
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                next      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                alu_op     = ALUOP_W'(ALU_ADD);
                instr_done = dec == S_FETCH;
                next       = dec;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(funct == FN_SUB ? ALU_SUB : funct == FN_SLT ? ALU_SLT :
                                     funct == FN_ADD ? ALU_ADD : ALU_NOP);
                next      = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_W'(ALU_XOR);
                next      = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = rtype ? DST_RD : DST_RT;
                instr_done = 1'b1;
                next       = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_W'(ALU_ADD);
                next      = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                next     = mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_MEM_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                next       = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                wb_sel     = WB_MDR;
                instr_done = 1'b1;
                next       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_src        = PC_ALUOUT;
                instr_done    = 1'b1;
                next          = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = rtype ? PC_RS : PC_JUMP;
                reg_write  = jal;
                reg_dst    = jal ? DST_RA : DST_RT;
                wb_sel     = jal ? WB_PC : WB_ALUOUT;
                instr_done = 1'b1;
                next       = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
            default:  next = S_IDLE;
        endcase
        // a wait cycle that hits the limit overrides the hold; mem_ready=1 never expires
        if (expire) next = S_HALT;
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench; each step queues (mem_ready, opcode, funct,
// expected output word) and is compared mid-cycle against the DUT's output word.
module tb_mips_multicycle_ctrl;
    // output word: {pc_write, pc_write_cond, pc_src, i_or_d, ir_write, mem_read, mem_write,
    //               reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, halted}
    localparam logic [23:0] PW = 24'h800000, PWC = 24'h400000, PS_ALUOUT = 24'h100000,
                            PS_J = 24'h200000, PS_JR = 24'h300000, IOD = 24'h080000,
                            IRW = 24'h040000, MR = 24'h020000, MW = 24'h010000, RW = 24'h008000,
                            RD_RD = 24'h002000, RD_RA = 24'h004000, WB_MDR = 24'h000800,
                            WB_PC = 24'h001000, SA = 24'h000400, SB_4 = 24'h000100,
                            SB_IMM = 24'h000200, SB_SH = 24'h000300, DONE = 24'h000002,
                            HLT = 24'h000001;
    localparam logic [23:0] A_ADD = 24'h000080, A_SUB = 24'h000088, A_SLT = 24'h0000A8,
                            A_XOR = 24'h000098;
    localparam logic [23:0] FW = MR | SB_4 | A_ADD, FR = FW | IRW | PW, DEC = SB_SH | A_ADD,
                            WBR = RW | RD_RD | DONE, WBI = RW | DONE, MA = SA | SB_IMM | A_ADD,
                            MRD = IOD | MR, MWR = IOD | MW, WBM = RW | WB_MDR | DONE;

    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, reg_write;
    logic alu_src_a, instr_done, halted, illegal_instr, mem_timeout;
    logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b;
    logic [5:0] alu_op;
    logic [23:0] obs;
    int checks = 0, failures = 0;

    typedef struct packed {logic r; logic [5:0] op; logic [5:0] fn; logic [23:0] e;} step_t;
    step_t sq[$];

    assign obs = {pc_write, pc_write_cond, pc_src, i_or_d, ir_write, mem_read, mem_write,
                  reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, halted};

    mips_multicycle_ctrl #(.ALUOP_W(6), .MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .i_or_d(i_or_d),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .instr_done(instr_done), .halted(halted),
        .illegal_instr(illegal_instr), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic [23:0] e);
        sq.push_back({r, op, fn, e});
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs !== 24'h0) begin failures++; $display("FAIL reset_outputs: obs=%h exp=000000", obs); end
        checks++;
        if ({illegal_instr, mem_timeout} !== 2'b00) begin
            failures++; $display("FAIL reset_flags: obs=%b exp=00", {illegal_instr, mem_timeout});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu;
        step_t s;
        int n = 0;
        push(1, 6'h00, 6'h20, FR); push(0, 6'h00, 6'h20, DEC); push(0, 6'h00, 6'h20, SA | A_ADD); push(0, 6'h00, 6'h20, WBR);
        push(1, 6'h00, 6'h22, FR); push(1, 6'h00, 6'h22, DEC); push(1, 6'h00, 6'h22, SA | A_SUB); push(1, 6'h00, 6'h22, WBR);
        push(1, 6'h00, 6'h2A, FR); push(0, 6'h00, 6'h2A, DEC); push(0, 6'h00, 6'h2A, SA | A_SLT); push(0, 6'h00, 6'h2A, WBR);
        push(1, 6'h0E, 6'h15, FR); push(0, 6'h0E, 6'h15, DEC); push(0, 6'h0E, 6'h15, SA | SB_IMM | A_XOR); push(0, 6'h0E, 6'h15, WBI);
        push(1, 6'h00, 6'h00, FR); push(0, 6'h00, 6'h00, DEC | DONE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL alu step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
    endtask

    task automatic test_mem;
        step_t s;
        int n = 0;
        repeat (3) push(0, 6'h23, 6'h01, FW);
        push(1, 6'h23, 6'h01, FR); push(0, 6'h23, 6'h01, DEC); push(0, 6'h23, 6'h01, MA);
        push(0, 6'h23, 6'h01, MRD); push(0, 6'h23, 6'h01, MRD); push(1, 6'h23, 6'h01, MRD);
        push(0, 6'h23, 6'h01, WBM);
        push(1, 6'h2B, 6'h02, FR); push(1, 6'h2B, 6'h02, DEC); push(0, 6'h2B, 6'h02, MA);
        repeat (3) push(0, 6'h2B, 6'h02, MWR);
        push(1, 6'h2B, 6'h02, MWR | DONE);
        push(1, 6'h00, 6'h00, FR); push(0, 6'h00, 6'h00, DEC | DONE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL mem step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
        checks++;
        if (mem_timeout !== 1'b0) begin failures++; $display("FAIL mem_no_timeout: obs=%b exp=0", mem_timeout); end
    endtask

    task automatic test_ctrl;
        step_t s;
        int n = 0;
        push(1, 6'h05, 6'h3F, FR); push(0, 6'h05, 6'h3F, DEC); push(0, 6'h05, 6'h3F, SA | A_SUB | PWC | PS_ALUOUT | DONE);
        push(1, 6'h02, 6'h00, FR); push(0, 6'h02, 6'h00, DEC); push(0, 6'h02, 6'h00, PW | PS_J | DONE);
        push(1, 6'h03, 6'h11, FR); push(0, 6'h03, 6'h11, DEC); push(0, 6'h03, 6'h11, PW | PS_J | DONE | RW | RD_RA | WB_PC);
        push(1, 6'h00, 6'h08, FR); push(0, 6'h00, 6'h08, DEC); push(0, 6'h00, 6'h08, PW | PS_JR | DONE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL ctrl step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
    endtask

    task automatic test_illegal;
        step_t s;
        int n = 0;
        push(1, 6'h3F, 6'h00, FR); push(0, 6'h3F, 6'h00, DEC | DONE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL illegal step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
        checks++;
        if (illegal_instr !== 1'b0) begin failures++; $display("FAIL illegal_before_exit: obs=%b exp=0", illegal_instr); end
        @(posedge clk); #1;
        checks++;
        if (illegal_instr !== 1'b1) begin failures++; $display("FAIL illegal_set: obs=%b exp=1", illegal_instr); end
        push(1, 6'h00, 6'h3F, FR); push(0, 6'h00, 6'h3F, DEC | DONE);
        push(1, 6'h00, 6'h20, FR); push(0, 6'h00, 6'h20, DEC); push(0, 6'h00, 6'h20, SA | A_ADD); push(0, 6'h00, 6'h20, WBR);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL illegal step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
        checks++;
        if (illegal_instr !== 1'b1) begin failures++; $display("FAIL illegal_sticky: obs=%b exp=1", illegal_instr); end
    endtask

    task automatic test_timeout;
        step_t s;
        int n = 0;
        push(1, 6'h2B, 6'h00, FR); push(0, 6'h2B, 6'h00, DEC); push(0, 6'h2B, 6'h00, MA);
        repeat (4) push(0, 6'h2B, 6'h00, MWR);
        push(0, 6'h2B, 6'h00, HLT); push(1, 6'h2B, 6'h00, HLT);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL timeout step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
        checks++;
        if (mem_timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag: obs=%b exp=1", mem_timeout); end
        rst_n = 1'b0; #1;
        checks++;
        if ({obs, illegal_instr, mem_timeout} !== 26'h0) begin
            failures++; $display("FAIL timeout_reset_clear: obs=%h flags=%b exp=000000/00", obs, {illegal_instr, mem_timeout});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_syscall;
        step_t s;
        int n = 0;
        push(1, 6'h00, 6'h0C, FR); push(0, 6'h00, 6'h0C, DEC);
        repeat (20) push(1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), HLT);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL syscall step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
    endtask

    task automatic test_reset_mid_lw;
        step_t s;
        int n = 0;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        push(0, 6'h23, 6'h00, FW); push(1, 6'h23, 6'h00, FR); push(0, 6'h23, 6'h00, DEC);
        push(0, 6'h23, 6'h00, MA); push(0, 6'h23, 6'h00, MRD);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL midlw step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 24'h0) begin failures++; $display("FAIL midlw_async_reset: obs=%h exp=000000", obs); end
        @(negedge clk); rst_n = 1'b1;
        push(1, 6'h00, 6'h00, FR); push(0, 6'h00, 6'h00, DEC | DONE);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk); mem_ready = s.r; opcode = s.op; funct = s.fn; #1;
            checks++; n++;
            if (obs !== s.e) begin failures++; $display("FAIL midlw step %0d: obs=%h exp=%h", n, obs, s.e); end
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mem;
        test_ctrl;
        test_illegal;
        test_timeout;
        test_syscall;
        test_reset_mid_lw;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
